// File: rtl/mux8_arbiter.sv
// mux8_arbiter: round-robin scheduler sharing one 8:1 single-bit mux among
// eight level requesters. A grant is held for at most HOLD_MAX consecutive
// cycles. On release or expiry the next winner is granted on the same edge,
// so there is no idle bubble between grants.

// Plain 8:1 single-bit multiplexer used as the shared data path.
module mux8_1 (
    input  logic [7:0] i_in,
    input  logic [2:0] i_sel,
    output logic       o_out
);

    assign o_out = i_in[i_sel];

endmodule

module mux8_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_req,
    input  logic [7:0] i_data,
    output logic [7:0] o_gnt,
    output logic [2:0] o_sel,
    output logic       o_valid,
    output logic       o_data_out
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Last value cnt may reach while the holder keeps the grant.
    localparam logic [3:0] CNT_LAST = 4'(HOLD_MAX - 1);

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [3:0] r_cnt;
    logic [7:0] r_gnt;
    logic [2:0] r_sel;
    logic       r_valid;

    state_t     w_state;
    logic [2:0] w_ptr;
    logic [3:0] w_cnt;
    logic [7:0] w_gnt;
    logic [2:0] w_sel;
    logic       w_valid;

    logic [2:0] w_start;
    logic [3:0] w_win;
    logic       w_keep;
    logic       w_mux_out;

    // Rotating-priority search: returns {found, index} of the first set
    // request at or after 'start', wrapping modulo 8. The scan runs from
    // the far end back toward 'start' so the closest match is written last.
    function automatic logic [3:0] find_winner(input logic [7:0] req,
                                               input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = start + 3'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state, next-grant and pointer update from current requests.
    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_cnt   = r_cnt;
        w_gnt   = r_gnt;
        w_sel   = r_sel;
        w_valid = r_valid;

        // Holder keeps the grant while it still requests and has budget left.
        w_keep = i_req[r_sel] && (r_cnt < CNT_LAST);

        // On release/expiry the search restarts just past the holder;
        // while idle it resumes from the saved pointer.
        if (r_state == ST_GRANT) begin
            w_start = r_sel + 3'd1;
        end else begin
            w_start = r_ptr;
        end
        w_win = find_winner(i_req, w_start);

        case (r_state)
            ST_IDLE: begin
                if (w_win[3]) begin
                    w_state = ST_GRANT;
                    w_gnt   = 8'(8'b0000_0001 << w_win[2:0]);
                    w_sel   = w_win[2:0];
                    w_valid = 1'b1;
                    w_cnt   = 4'd0;
                end else begin
                    w_gnt   = 8'h00;
                    w_valid = 1'b0;
                end
            end
            ST_GRANT: begin
                if (w_keep) begin
                    w_cnt = r_cnt + 4'd1;
                end else begin
                    w_ptr = w_start;
                    if (w_win[3]) begin
                        w_state = ST_GRANT;
                        w_gnt   = 8'(8'b0000_0001 << w_win[2:0]);
                        w_sel   = w_win[2:0];
                        w_valid = 1'b1;
                        w_cnt   = 4'd0;
                    end else begin
                        w_state = ST_IDLE;
                        w_gnt   = 8'h00;
                        w_valid = 1'b0;
                        w_cnt   = 4'd0;
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_gnt   = 8'h00;
                w_valid = 1'b0;
                w_cnt   = 4'd0;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 3'd0;
            r_cnt   <= 4'd0;
            r_gnt   <= 8'h00;
            r_sel   <= 3'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_cnt   <= w_cnt;
            r_gnt   <= w_gnt;
            r_sel   <= w_sel;
            r_valid <= w_valid;
        end
    end

    mux8_1 u_mux (
        .i_in  (i_data),
        .i_sel (r_sel),
        .o_out (w_mux_out)
    );

    assign o_gnt      = r_gnt;
    assign o_sel      = r_sel;
    assign o_valid    = r_valid;
    assign o_data_out = w_mux_out & r_valid;

endmodule

// File: tb/tb_mux8_arbiter.sv
// Testbench for mux8_arbiter: two instances (HOLD_MAX 4 and 1) share the
// same stimulus. A reference model predicts each cycle's registered outputs
// into per-instance queues; a negedge monitor pops and compares.
module tb_mux8_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] i_req;
    logic [7:0] i_data;

    logic [7:0] gnt4, gnt1;
    logic [2:0] sel4, sel1;
    logic       valid4, valid1;
    logic       dout4, dout1;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state, index 0 = HOLD_MAX 4, index 1 = HOLD_MAX 1.
    int m_hm     [2] = '{4, 1};
    int m_holder [2];   // -1 when nobody holds the resource
    int m_held   [2];   // cycles the current holder has had the grant
    int m_ptr    [2];
    int m_sel    [2];

    logic [11:0] q0[$];
    logic [11:0] q1[$];

    mux8_arbiter #(.HOLD_MAX(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_data(i_data),
        .o_gnt(gnt4), .o_sel(sel4), .o_valid(valid4), .o_data_out(dout4)
    );

    mux8_arbiter #(.HOLD_MAX(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_data(i_data),
        .o_gnt(gnt1), .o_sel(sel1), .o_valid(valid1), .o_data_out(dout1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    endtask

    function automatic int scan(input logic [7:0] r, input int start);
        for (int j = 0; j < 8; j++) begin
            if (r[(start + j) % 8]) return (start + j) % 8;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_holder[k] = -1;
            m_held[k]   = 0;
            m_ptr[k]    = 0;
            m_sel[k]    = 0;
        end
    endfunction

    // One clock of the arbitration rules for model k.
    function automatic void model_step(input int k, input logic [7:0] r);
        int w;
        if (m_holder[k] < 0) begin
            w = scan(r, m_ptr[k]);
            if (w >= 0) begin
                m_holder[k] = w;
                m_held[k]   = 1;
                m_sel[k]    = w;
            end
        end else if (r[m_holder[k]] && m_held[k] < m_hm[k]) begin
            m_held[k]++;
        end else begin
            m_ptr[k] = (m_holder[k] + 1) % 8;
            w = scan(r, m_ptr[k]);
            m_holder[k] = w;
            if (w >= 0) begin
                m_held[k] = 1;
                m_sel[k]  = w;
            end
        end
    endfunction

    function automatic logic [11:0] model_out(input int k);
        logic [7:0] g;
        g = 8'h00;
        if (m_holder[k] >= 0) g[m_holder[k]] = 1'b1;
        return {g, 3'(m_sel[k]), (m_holder[k] >= 0)};
    endfunction

    // Scoreboard producer: advance the model on every edge, flush on reset.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
                q0.delete();
                q1.delete();
            end else begin
                model_step(0, i_req);
                model_step(1, i_req);
                q0.push_back(model_out(0));
                q1.push_back(model_out(1));
            end
        end
    end

    // Monitor: compare registered outputs and data_out mid-cycle.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("hm4_outputs", {gnt4, sel4, valid4, dout4},
                    {e, e[0] & i_data[e[3:1]]});
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("hm1_outputs", {gnt1, sel1, valid1, dout1},
                    {e, e[0] & i_data[e[3:1]]});
            end
        end
    end

    task automatic step(input logic [7:0] r, input logic [7:0] d, input int n);
        i_req  = r;
        i_data = d;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        logic [7:0] r;
        bit         got;
        rst_n  = 1'b1;
        i_req  = 8'h00;
        i_data = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_state", {gnt4, sel4, valid4, dout4, gnt1, sel1, valid1, dout1}, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed patterns, checked by the scoreboard.
        step(8'h00, 8'hFF, 5);
        step(8'h24, 8'h20, 12);
        step(8'h00, 8'h00, 2);
        step(8'h01, 8'h01, 10);
        step(8'h08, 8'h08, 3);
        step(8'h81, 8'h81, 10);

        // HOLD_MAX=1 rotation from a fresh pointer.
        rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        i_req  = 8'hFF;
        i_data = 8'b1010_1010;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            chk("hm1_rotate_sel", sel1, i % 8);
            chk("hm1_rotate_dout", dout1, i % 2);
        end
        #1;

        // Randomized level requests.
        r = 8'h00;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0:       r = 8'($urandom);
                1, 2:    r[$urandom_range(0, 7)] = ~r[$urandom_range(0, 7)];
                3:       if ($urandom_range(0, 3) == 0) r = 8'h00;
                default: r = r;
            endcase
            step(r, 8'($urandom), 1);
        end

        // Reset in the middle of a grant to requester 4.
        i_req = 8'h10;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (gnt4 == 8'h10) got = 1'b1;
            else step(8'h10, i_data, 1);
        end
        chk("wait_gnt_0x10", got, 1'b1);
        step(8'h10, i_data, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_clear", {gnt4, sel4, valid4, gnt1, sel1, valid1}, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        i_req = 8'h10;
        @(posedge clk);
        #1;
        chk("regrant_after_reset", gnt4, 8'h10);
        #1;
        step(8'h10, 8'h10, 3);
        step(8'h00, 8'h00, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux8_arbiter.md
# mux8_arbiter

Round-robin scheduler that shares one `mux8_1` data path among eight requesters. It grants one requester at a time and drives the mux select from the registered grant index. A grant lasts at most `HOLD_MAX` consecutive cycles, so no single requester can starve the others. It sits in front of any single-bit shared resource in the processor that is fed through `mux8_1`, such as a shared status or serial line.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive cycles one grant is held. Legal range 1..16.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-low. Asserting it (0) clears all state immediately. Release is sampled on `clk`.
- `req` in 8: level request, one bit per requester. `req[i]` stays high while requester i wants the resource.
- `data` in 8: per-requester data bit, fed to the internal `mux8_1` `in`.
- `gnt` out 8: registered one-hot grant. All zero when idle.
- `sel` out 3: registered index of the current or last winner. Drives `mux8_1` `sel`.
- `valid` out 1: registered; 1 iff `gnt` is non-zero.
- `data_out` out 1: `mux8_1` output ANDed with `valid`. Combinational from `data`, `sel` and `valid`.

## Operation
- Internal state:
  - `state` ∈ {IDLE, GRANT}.
  - `ptr` (3 bits): search start index.
  - `cnt` (4 bits): cycles already spent in the current grant.
- Winner search: the first `i` with `req[i]`=1, scanning `ptr`, `ptr`+1, … `ptr`+7, all mod 8. Only current-cycle `req` is used.
- IDLE:
  - If `req` = 0, stay in IDLE with `gnt`=0 and `valid`=0. `sel` holds its last value.
  - If `req` ≠ 0, at the next edge: `gnt`=onehot(winner), `sel`=winner, `valid`=1, `cnt`=0, go to GRANT.
- GRANT (holder `g` = `sel`):
  - If `req[g]`=1 and `cnt` < `HOLD_MAX`−1: keep `gnt` and `sel`, `cnt`+=1.
  - Otherwise (release or expiry): `ptr`=`g`+1 mod 8, then search using this new `ptr` in the same cycle.
    - Winner found: grant it at the edge with no idle bubble, `cnt`=0, stay in GRANT.
    - No winner: `gnt`=0, `valid`=0, go to IDLE.
- Expiry with `g` as the only requester: the scan wraps back to `g`, so `g` is re-granted and `cnt` resets to 0.
- `HOLD_MAX`=1: every grant lasts exactly one cycle; rotation happens on every edge.
- `ptr` changes only on release or expiry. In IDLE it keeps its value, so fairness carries across idle periods.
- Reset asserted at any time, including mid-grant: `gnt`=0, `sel`=0, `valid`=0, `ptr`=0, `cnt`=0, `state`=IDLE. Outputs clear asynchronously.

## Timing
- Request to grant: 1 cycle. `req` seen high at edge N gives `gnt` at edge N+1.
- Grant switch on release or expiry: 0 bubble cycles. The new `gnt` appears on the same edge the old one drops.
- `req[g]` dropped in cycle C: `gnt[g]` falls at the end of cycle C. The holder always keeps the grant for at least 1 cycle.
- A grant is never held longer than `HOLD_MAX` consecutive cycles while other requests are pending.
- `gnt`, `sel` and `valid` are glitch-free registers. `data_out` settles combinationally after `data` changes.
- Simultaneous requests: resolved by rotating priority from `ptr`, never by fixed index.
- `gnt` is always one-hot or zero; `valid` always equals |`gnt`.

## Test plan
- Reset, then `req`=8'h00 for 5 cycles -> `gnt`=0, `valid`=0, `sel`=0, `data_out`=0 throughout.
- Reset, `req`=8'h24 held, `HOLD_MAX`=4 -> `gnt`=8'h04 for 4 cycles, then 8'h20 for 4 cycles, then 8'h04 again. `valid` stays 1 with no gap.
- `req`=8'h01 held alone, `HOLD_MAX`=4 -> `gnt`=8'h01 continuous. `cnt` wraps every 4 cycles and `sel` stays 0.
- Requester 3 granted, `req[3]` dropped after 2 cycles while `req`=8'h81 -> next grant is 8'h80 (index 7 is first at or after `ptr`=4), then 8'h01.
- `req`=8'hFF, `data`=8'b1010_1010, `HOLD_MAX`=1 -> `sel` sequence 0,1,2…7,0 and `data_out` sequence 0,1,0,1…
- Assert `reset` mid-grant with `gnt`=8'h10 -> `gnt`, `valid` and `sel` go to 0 without waiting for a clock edge. After release with `req`=8'h10, `gnt`=8'h10 one cycle later.
